// File: rtl/cla_seq_adder_ctrl.sv
// Nibble-serial add/subtract controller driving an external 4-bit CLA slice.
// Operands are consumed LSB nibble first; carry is chained through carry_q.
module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_cout
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic            cout_q;
  logic            ovf_q;
  logic            accept;
  logic            last;
  logic            ovf_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (idx_q == LAST);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  // slice_sum[3] is the final result MSB on the last nibble
  assign ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                 (slice_sum[3] != a_q[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    unique case (1'b1)
      (state_q == RUN): begin
        slice_a   = a_q[4*idx_q +: 4];
        slice_b   = b_q[4*idx_q +: 4];
        slice_cin = carry_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= sub ? ~op_b : op_b;
      carry_q <= sub | cin;
      idx_q   <= '0;
      sum_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[4*idx_q +: 4] <= slice_sum;
      carry_q <= slice_cout;
      idx_q   <= last ? '0 : idx_q + 1'b1;
      if (last) begin
        cout_q <= slice_cout;
        ovf_q  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Randomised + directed bench for cla_seq_adder_ctrl with an in-bench slice.
// A per-cycle compare process checks the DUT against an arithmetic model.
module tb_cla_seq_adder_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic         slice_cin;
  logic [3:0]   slice_sum;
  logic         slice_cout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // external 4-bit adder slice
  assign {slice_cout, slice_sum} =
    {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

  cla_seq_adder_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .sub        (sub),
    .cin        (cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .ovf        (ovf),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // model: 0 idle, 1 computing, 2 result held
  int           m_phase = 0;
  int           m_cnt = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic         m_c = 1'b0;
  logic         chk_on = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_a     <= op_a;
          m_b     <= sub ? ~op_b : op_b;
          m_c     <= sub | cin;
          m_cnt   <= NIB;
          m_phase <= 1;
        end
        1: if (m_cnt == 1) m_phase <= 2;
           else m_cnt <= m_cnt - 1;
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  logic [W:0]  e_full;
  logic [31:0] e_mask;
  logic [31:0] e_car;
  int          e_idx;
  logic [3:0]  q_sa[$];
  logic        q_sc[$];

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      e_full = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_c};
      check("in_ready", in_ready, m_phase == 0);
      check("out_valid", out_valid, m_phase == 2);
      if (m_phase == 2) begin
        check("sum", sum, e_full[W-1:0]);
        check("cout", cout, e_full[W]);
        check("ovf", ovf, (m_a[W-1] == m_b[W-1]) &&
                          (e_full[W-1] != m_a[W-1]));
      end
      if (m_phase == 1) begin
        e_idx  = NIB - m_cnt;
        e_mask = (32'd1 << (4 * e_idx)) - 32'd1;
        e_car  = ((32'(m_a) & e_mask) + (32'(m_b) & e_mask)
                  + 32'(m_c)) >> (4 * e_idx);
        check("slice_a", slice_a, (m_a >> (4 * e_idx)) & 16'hF);
        check("slice_b", slice_b, (m_b >> (4 * e_idx)) & 16'hF);
        check("slice_cin", slice_cin, e_car);
        q_sa.push_back(slice_a);
        q_sc.push_back(slice_cin);
      end else begin
        check("slice_idle", {slice_a, slice_b, slice_cin}, 0);
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c,
                          output int waited);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub  = s;
    cin  = c;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("accept_timeout", waited, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_op(input logic [W-1:0] es, input logic eco,
                           input logic eov, input bit lit, input int bp);
    int lat;
    logic [W+1:0] held;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, NIB);
    if (lit) begin
      check("lit_sum", sum, es);
      check("lit_cout", cout, eco);
      check("lit_ovf", ovf, eov);
    end
    held = {sum, cout, ovf};
    in_valid = (bp > 0);
    op_a = 16'($urandom);
    op_b = 16'($urandom);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_hold", {sum, cout, ovf}, held);
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drop_valid", out_valid, 0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         c;
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
    int           bp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    vecs[0] = '{16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0, 0};
    vecs[1] = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 3};
    vecs[2] = '{16'hFFFF, 16'h0000, 0, 1, 16'h0000, 1, 0, 0};
    vecs[3] = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0};
    vecs[4] = '{16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, 1};
    vecs[5] = '{16'h0005, 16'h0007, 1, 1, 16'hFFFE, 0, 0, 0};
    vecs[6] = '{16'h0009, 16'h0003, 1, 0, 16'h0006, 1, 0, 2};

    @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    chk_on = 1'b1;

    q_sa.delete();
    q_sc.delete();
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, w);
      if (i > 0) check("b2b_accept", w, 0);
      finish_op(vecs[i].es, vecs[i].eco, vecs[i].eov, 1'b1, vecs[i].bp);
      if (i == 0) begin
        check("seq_len", q_sa.size(), 4);
        if (q_sa.size() == 4) begin
          check("seq_a", {q_sa[0], q_sa[1], q_sa[2], q_sa[3]}, 16'hFF00);
          check("seq_cin", {q_sc[0], q_sc[1], q_sc[2], q_sc[3]}, 4'b0110);
        end
      end
    end

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 8 == 0) rb = ~ra;
      start_op(ra, rb, 1'($urandom), 1'($urandom), w);
      finish_op('0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 2));
    end

    start_op(16'h1111, 16'h2222, 1'b0, 1'b0, w);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_out", {sum, cout, ovf}, 0);
    check("mid_rst_slice", {slice_a, slice_b, slice_cin}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_stale_valid", seen, 0);
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0, w);
    finish_op(16'h5555, 1'b0, 1'b0, 1'b1, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
